// File: rtl/ll_cmd_arbiter_pkg.sv
// Shared linked-list types for the command arbiter: field widths, opcode
// encoding and the packed command record held in the output register.
package ll_cmd_arbiter_pkg;

  localparam int LL_KEY_WIDTH      = 8;
  localparam int LL_HEAD_PTR_WIDTH = 6;

  typedef enum logic [1:0] {
    LL_OP_LOOKUP = 2'd0,
    LL_OP_INSERT = 2'd1,
    LL_OP_DELETE = 2'd2,
    LL_OP_NOP    = 2'd3
  } ll_opcode_e;

  typedef struct packed {
    logic [LL_KEY_WIDTH-1:0]      key;
    ll_opcode_e                   opcode;
    logic [LL_HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                         head_ptr_val;
  } ll_cmd_t;

endpackage

// File: rtl/ll_cmd_arbiter_owner_fifo.sv
// In-order FIFO of requester indices: one entry per command in flight, the
// head names the requester that owns the next result from the linked list.
module ll_owner_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q;
  logic [PTR_W-1:0]  rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              push_s;
  logic              pop_s;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == {CNT_W{1'b0}});
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Occupancy next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and count; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_q  <= {PTR_W{1'b0}};
      rd_q  <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ll_cmd_arbiter.sv
// Round-robin sharing of one linked-list command port among N_REQ requesters,
// with in-order owner tracking to route results and head-table writes back.
module ll_cmd_arbiter
  import ll_cmd_arbiter_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int OWN_DEPTH = 4,
  localparam int IDX_W     = $clog2(N_REQ),
  localparam int CNT_W     = $clog2(OWN_DEPTH + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  input  logic [N_REQ-1:0]                        req_valid_i,
  output logic [N_REQ-1:0]                        req_ready_o,
  input  logic [N_REQ-1:0][LL_KEY_WIDTH-1:0]      req_key_i,
  input  logic [N_REQ-1:0][1:0]                   req_opcode_i,
  input  logic [N_REQ-1:0][LL_HEAD_PTR_WIDTH-1:0] req_head_ptr_i,
  input  logic [N_REQ-1:0]                        req_head_ptr_val_i,
  output logic                                    ll_cmd_valid_o,
  input  logic                                    ll_cmd_ready_i,
  output logic [LL_KEY_WIDTH-1:0]                 ll_cmd_key_o,
  output logic [1:0]                              ll_cmd_opcode_o,
  output logic [LL_HEAD_PTR_WIDTH-1:0]            ll_cmd_head_ptr_o,
  output logic                                    ll_cmd_head_ptr_val_o,
  input  logic                                    ll_res_valid_i,
  output logic                                    ll_res_ready_o,
  input  logic [LL_KEY_WIDTH-1:0]                 ll_res_key_i,
  input  logic [1:0]                              ll_res_opcode_i,
  input  logic [2:0]                              ll_res_rescode_i,
  input  logic [2:0]                              ll_res_chain_state_i,
  input  logic                                    ll_ht_wr_en_i,
  input  logic [LL_HEAD_PTR_WIDTH-1:0]            ll_ht_wr_data_ptr_i,
  input  logic                                    ll_ht_wr_data_ptr_val_i,
  output logic [N_REQ-1:0]                        rsp_valid_o,
  input  logic [N_REQ-1:0]                        rsp_ready_i,
  output logic [LL_KEY_WIDTH-1:0]                 rsp_key_o,
  output logic [1:0]                              rsp_opcode_o,
  output logic [2:0]                              rsp_rescode_o,
  output logic [2:0]                              rsp_chain_state_o,
  output logic [N_REQ-1:0]                        rsp_ht_wr_en_o,
  output logic [LL_HEAD_PTR_WIDTH-1:0]            rsp_ht_ptr_o,
  output logic                                    rsp_ht_ptr_val_o,
  output logic [CNT_W-1:0]                        outstanding_o,
  output logic                                    err_o
);

  ll_cmd_t          cmd_q, cmd_d;
  logic             ovalid_q, ovalid_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] grant_idx_s;
  logic             grant_found_s;
  logic             load_s;
  logic             pop_s;
  logic [IDX_W-1:0] head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // Round-robin search beginning just after the last granted requester.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    cand          = 0;
    cand_idx      = {IDX_W{1'b0}};
    grant_found_s = 1'b0;
    grant_idx_s   = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand     = (int'(last_q) + 1 + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found_s && req_valid_i[cand_idx]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_idx;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Full FIFO blocks the load outright so result handshakes never reach req_ready_o.
  assign load_s = (~ovalid_q | ll_cmd_ready_i) & ~fifo_full_s & grant_found_s;

  // Grant strobe and output-register next state.
  always_comb begin
    req_ready_o = {N_REQ{1'b0}};
    cmd_d       = cmd_q;
    ovalid_d    = ovalid_q;
    last_d      = last_q;
    if (load_s) begin
      req_ready_o[grant_idx_s] = 1'b1;
      cmd_d.key                = req_key_i[grant_idx_s];
      cmd_d.opcode             = ll_opcode_e'(req_opcode_i[grant_idx_s]);
      cmd_d.head_ptr           = req_head_ptr_i[grant_idx_s];
      cmd_d.head_ptr_val       = req_head_ptr_val_i[grant_idx_s];
      ovalid_d                 = 1'b1;
      last_d                   = grant_idx_s;
    end else if (ll_cmd_ready_i) begin
      ovalid_d = 1'b0;
    end else begin
      ovalid_d = ovalid_q;
    end
  end

  // Result and head-table routing to the owner at the FIFO head.
  always_comb begin
    rsp_valid_o    = {N_REQ{1'b0}};
    rsp_ht_wr_en_o = {N_REQ{1'b0}};
    ll_res_ready_o = 1'b0;
    if (fifo_empty_s) begin
      ll_res_ready_o = ll_res_valid_i;
    end else begin
      rsp_valid_o[head_s]    = ll_res_valid_i;
      rsp_ht_wr_en_o[head_s] = ll_ht_wr_en_i;
      ll_res_ready_o         = rsp_ready_i[head_s];
    end
  end

  assign pop_s = ll_res_valid_i & ll_res_ready_o & ~fifo_empty_s;
  assign err_d = err_q | (fifo_empty_s & (ll_res_valid_i | ll_ht_wr_en_i));

  // Output register, round-robin pointer and sticky error.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cmd_q    <= '0;
      ovalid_q <= 1'b0;
      last_q   <= IDX_W'(N_REQ - 1);
      err_q    <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      ovalid_q <= ovalid_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  ll_owner_fifo #(
    .DEPTH  (OWN_DEPTH),
    .DATA_W (IDX_W)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (load_s),
    .data_i  (grant_idx_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .count_o (outstanding_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign ll_cmd_valid_o        = ovalid_q;
  assign ll_cmd_key_o          = cmd_q.key;
  assign ll_cmd_opcode_o       = cmd_q.opcode;
  assign ll_cmd_head_ptr_o     = cmd_q.head_ptr;
  assign ll_cmd_head_ptr_val_o = cmd_q.head_ptr_val;
  assign rsp_key_o             = ll_res_key_i;
  assign rsp_opcode_o          = ll_res_opcode_i;
  assign rsp_rescode_o         = ll_res_rescode_i;
  assign rsp_chain_state_o     = ll_res_chain_state_i;
  assign rsp_ht_ptr_o          = ll_ht_wr_data_ptr_i;
  assign rsp_ht_ptr_val_o      = ll_ht_wr_data_ptr_val_i;
  assign err_o                 = err_q;

endmodule

// File: tb/tb_ll_cmd_arbiter.sv
// Directed self-checking bench for ll_cmd_arbiter with hand-computed grants,
// routing, backpressure and error behaviour.
module tb_ll_cmd_arbiter;
  import ll_cmd_arbiter_pkg::*;

  logic                                clk;
  logic                                rst_n;
  logic [3:0]                          req_valid;
  logic [3:0]                          req_ready;
  logic [3:0][LL_KEY_WIDTH-1:0]        req_key;
  logic [3:0][1:0]                     req_opcode;
  logic [3:0][LL_HEAD_PTR_WIDTH-1:0]   req_head_ptr;
  logic [3:0]                          req_head_ptr_val;
  logic                                ll_cmd_valid;
  logic                                ll_cmd_ready;
  logic [LL_KEY_WIDTH-1:0]             ll_cmd_key;
  logic [1:0]                          ll_cmd_opcode;
  logic [LL_HEAD_PTR_WIDTH-1:0]        ll_cmd_head_ptr;
  logic                                ll_cmd_head_ptr_val;
  logic                                ll_res_valid;
  logic                                ll_res_ready;
  logic [LL_KEY_WIDTH-1:0]             ll_res_key;
  logic [1:0]                          ll_res_opcode;
  logic [2:0]                          ll_res_rescode;
  logic [2:0]                          ll_res_chain_state;
  logic                                ll_ht_wr_en;
  logic [LL_HEAD_PTR_WIDTH-1:0]        ll_ht_ptr;
  logic                                ll_ht_ptr_val;
  logic [3:0]                          rsp_valid;
  logic [3:0]                          rsp_ready;
  logic [LL_KEY_WIDTH-1:0]             rsp_key;
  logic [1:0]                          rsp_opcode;
  logic [2:0]                          rsp_rescode;
  logic [2:0]                          rsp_chain_state;
  logic [3:0]                          rsp_ht_wr_en;
  logic [LL_HEAD_PTR_WIDTH-1:0]        rsp_ht_ptr;
  logic                                rsp_ht_ptr_val;
  logic [2:0]                          outstanding;
  logic                                err;

  int checks = 0;
  int errors = 0;

  ll_cmd_arbiter #(.N_REQ(4), .OWN_DEPTH(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_key_i(req_key),
    .req_opcode_i(req_opcode), .req_head_ptr_i(req_head_ptr),
    .req_head_ptr_val_i(req_head_ptr_val),
    .ll_cmd_valid_o(ll_cmd_valid), .ll_cmd_ready_i(ll_cmd_ready),
    .ll_cmd_key_o(ll_cmd_key), .ll_cmd_opcode_o(ll_cmd_opcode),
    .ll_cmd_head_ptr_o(ll_cmd_head_ptr), .ll_cmd_head_ptr_val_o(ll_cmd_head_ptr_val),
    .ll_res_valid_i(ll_res_valid), .ll_res_ready_o(ll_res_ready),
    .ll_res_key_i(ll_res_key), .ll_res_opcode_i(ll_res_opcode),
    .ll_res_rescode_i(ll_res_rescode), .ll_res_chain_state_i(ll_res_chain_state),
    .ll_ht_wr_en_i(ll_ht_wr_en), .ll_ht_wr_data_ptr_i(ll_ht_ptr),
    .ll_ht_wr_data_ptr_val_i(ll_ht_ptr_val),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_key_o(rsp_key),
    .rsp_opcode_o(rsp_opcode), .rsp_rescode_o(rsp_rescode),
    .rsp_chain_state_o(rsp_chain_state), .rsp_ht_wr_en_o(rsp_ht_wr_en),
    .rsp_ht_ptr_o(rsp_ht_ptr), .rsp_ht_ptr_val_o(rsp_ht_ptr_val),
    .outstanding_o(outstanding), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b0; ll_cmd_ready = 1'b0; ll_res_valid = 1'b0; rsp_ready = 4'b0;
    ll_ht_wr_en = 1'b0; ll_ht_ptr = 6'h0; ll_ht_ptr_val = 1'b0;
    ll_res_key = 8'h0; ll_res_opcode = 2'd0; ll_res_rescode = 3'd0; ll_res_chain_state = 3'd0;
    for (int i = 0; i < 4; i++) begin
      req_key[i] = 8'hA0 + 8'(i);
      req_opcode[i] = 2'd1;
      req_head_ptr[i] = 6'(i);
      req_head_ptr_val[i] = 1'b1;
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (ll_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b want 0", ll_cmd_valid); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if ({req_ready, rsp_valid, rsp_ht_wr_en, ll_res_ready} !== 13'd0) begin
      errors++; $display("FAIL reset_comb got %b want 0", {req_ready, rsp_valid, rsp_ht_wr_en, ll_res_ready}); end
  endtask

  task automatic test_single();
    do_reset();
    req_key[2] = 8'h11;
    req_opcode[2] = 2'd1;
    req_valid = 4'b0100;
    ll_cmd_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0;
    checks++; if (ll_cmd_valid !== 1'b1 || ll_cmd_key !== 8'h11 || ll_cmd_opcode !== 2'd1) begin
      errors++; $display("FAIL single_cmd got v=%b k=%h op=%0d want v=1 k=11 op=1", ll_cmd_valid, ll_cmd_key, ll_cmd_opcode); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding got %0d want 1", outstanding); end
    tick();
    ll_res_valid = 1'b1;
    ll_res_key = 8'h11;
    rsp_ready = 4'b0100;
    #1;
    checks++; if (rsp_valid !== 4'b0100 || ll_res_ready !== 1'b1 || rsp_key !== 8'h11) begin
      errors++; $display("FAIL single_route got v=%b r=%b k=%h want 0100 1 11", rsp_valid, ll_res_ready, rsp_key); end
    tick();
    ll_res_valid = 1'b0;
    rsp_ready = 4'b0;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_drain got %0d want 0", outstanding); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    logic [3:0] exp_rsp;
    logic [7:0] exp_key;
    do_reset();
    req_valid = 4'b1111;
    ll_cmd_ready = 1'b1;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      ll_res_valid = (k > 0);
      #1;
      exp_ready = 4'b0001 << (k % 4);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, exp_ready); end
      if (k > 0) begin
        exp_rsp = 4'b0001 << ((k - 1) % 4);
        checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rr_route%0d got %b want %b", k, rsp_valid, exp_rsp); end
      end
      tick();
      exp_key = 8'hA0 + 8'(k % 4);
      checks++; if (ll_cmd_key !== exp_key) begin errors++; $display("FAIL rr_key%0d got %h want %h", k, ll_cmd_key, exp_key); end
    end
    req_valid = 4'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL rr_last_route got %b want 0010", rsp_valid); end
    tick();
    ll_res_valid = 1'b0;
    rsp_ready = 4'b0;
    checks++; if (outstanding !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL rr_drain got cnt=%0d err=%b want 0 0", outstanding, err); end
  endtask

  task automatic test_stall();
    logic [3:0] exp_g [3];
    logic [7:0] exp_k [3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001;
    exp_k[0] = 8'hA1;   exp_k[1] = 8'hA3;   exp_k[2] = 8'hA0;
    do_reset();
    req_valid = 4'b1011;
    ll_cmd_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0 || ll_cmd_valid !== 1'b1 || ll_cmd_key !== 8'hA0 || ll_cmd_head_ptr !== 6'd0) begin
        errors++; $display("FAIL stall%0d got rdy=%b v=%b k=%h want 0000 1 a0", c, req_ready, ll_cmd_valid, ll_cmd_key); end
      tick();
    end
    ll_cmd_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== exp_g[c]) begin errors++; $display("FAIL stall_resume%0d got %b want %b", c, req_ready, exp_g[c]); end
      tick();
      checks++; if (ll_cmd_key !== exp_k[c]) begin errors++; $display("FAIL stall_key%0d got %h want %h", c, ll_cmd_key, exp_k[c]); end
    end
    req_valid = 4'b0;
  endtask

  task automatic test_full();
    do_reset();
    req_valid = 4'b0001;
    ll_cmd_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    #1;
    checks++; if (outstanding !== 3'd4 || req_ready !== 4'b0) begin
      errors++; $display("FAIL full_block got cnt=%0d rdy=%b want 4 0000", outstanding, req_ready); end
    tick();
    ll_res_valid = 1'b1;
    rsp_ready = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0 || ll_res_ready !== 1'b1 || rsp_valid !== 4'b0001) begin
      errors++; $display("FAIL full_pop_cycle got rdy=%b rr=%b v=%b want 0000 1 0001", req_ready, ll_res_ready, rsp_valid); end
    tick();
    ll_res_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL full_resume got cnt=%0d rdy=%b want 3 0001", outstanding, req_ready); end
    tick();
    req_valid = 4'b0;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill got %0d want 4", outstanding); end
  endtask

  task automatic test_ht_backpressure();
    do_reset();
    req_valid = 4'b0010;
    ll_cmd_ready = 1'b1;
    tick();
    req_valid = 4'b0;
    tick();
    ll_res_valid = 1'b1;
    ll_ht_wr_en = 1'b1;
    ll_ht_ptr = 6'h15;
    ll_ht_ptr_val = 1'b1;
    rsp_ready = 4'b0;
    #1;
    checks++; if (rsp_ht_wr_en !== 4'b0010 || rsp_valid !== 4'b0010 || ll_res_ready !== 1'b0 || rsp_ht_ptr !== 6'h15) begin
      errors++; $display("FAIL ht_first got ht=%b v=%b r=%b p=%h want 0010 0010 0 15", rsp_ht_wr_en, rsp_valid, ll_res_ready, rsp_ht_ptr); end
    tick();
    ll_ht_wr_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (rsp_ht_wr_en !== 4'b0 || rsp_valid !== 4'b0010 || outstanding !== 3'd1) begin
        errors++; $display("FAIL ht_hold%0d got ht=%b v=%b cnt=%0d want 0000 0010 1", c, rsp_ht_wr_en, rsp_valid, outstanding); end
      tick();
    end
    rsp_ready = 4'b0010;
    #1;
    checks++; if (ll_res_ready !== 1'b1) begin errors++; $display("FAIL ht_accept got %b want 1", ll_res_ready); end
    tick();
    ll_res_valid = 1'b0;
    checks++; if (outstanding !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL ht_drain got cnt=%0d err=%b want 0 0", outstanding, err); end
  endtask

  task automatic test_empty_error();
    do_reset();
    ll_res_valid = 1'b1;
    #1;
    checks++; if (ll_res_ready !== 1'b1 || rsp_valid !== 4'b0) begin
      errors++; $display("FAIL empty_drop got r=%b v=%b want 1 0000", ll_res_ready, rsp_valid); end
    tick();
    ll_res_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL empty_err got %b want 1", err); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (err !== 1'b0 || outstanding !== 3'd0) begin
      errors++; $display("FAIL empty_reset got err=%b cnt=%0d want 0 0", err, outstanding); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_full();
    test_ht_backpressure();
    test_empty_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
